// File: rtl/fabric_pe_load_q.sv
// Load adapter PE: issues addresses to memory, tracks request tags in an in-order FIFO
// and re-tags returning data into a registered output. Optional error flags: FABRIC_PE_LOADQ_ERR_EN.
module fabric_pe_load_q #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int TAG_WIDTH   = 0,
    parameter int HW_TYPE     = 0,
    parameter int QUEUE_DEPTH = 4,
    localparam int TW    = (TAG_WIDTH > 0) ? TAG_WIDTH : 1,
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in0_valid,
    output logic                          in0_ready,
    input  logic [ADDR_WIDTH+TAG_WIDTH-1:0] in0_data,
    input  logic                          in1_valid,
    output logic                          in1_ready,
    input  logic [DATA_WIDTH-1:0]         in1_data,
    input  logic                          in2_valid,
    output logic                          in2_ready,
    input  logic [TW-1:0]                 in2_data,
    output logic                          out0_valid,
    input  logic                          out0_ready,
    output logic [DATA_WIDTH+TAG_WIDTH-1:0] out0_data,
    output logic                          out1_valid,
    input  logic                          out1_ready,
    output logic [ADDR_WIDTH+TAG_WIDTH-1:0] out1_data,
    input  logic [TW-1:0]                 cfg_data,
    output logic [CNT_W-1:0]              pending,
    output logic                          err_valid,
    output logic [3:0]                    err_code
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int OW    = DATA_WIDTH + TAG_WIDTH;

    if (DATA_WIDTH < 1 || ADDR_WIDTH < 1 || TAG_WIDTH < 0 ||
        (HW_TYPE != 0 && HW_TYPE != 1) || (HW_TYPE == 1 && TAG_WIDTH == 0) ||
        QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_param
        $fatal(1, "fabric_pe_load_q: illegal parameter combination");
    end

    logic [ADDR_WIDTH-1:0] in0_addr;
    logic [TW-1:0]         in0_tag;
    logic [TW-1:0]         issue_tag;
    logic [TW-1:0]         head_tag;
    logic [OW-1:0]         ret_word;
    logic                  tag_ok;
    logic                  q_empty;
    logic                  q_full;
    logic                  sync;
    logic                  push;
    logic                  pop;

    logic [CNT_W-1:0] count_q, count_d;
    logic             out0_valid_q, out0_valid_d;
    logic [OW-1:0]    out0_data_q, out0_data_d;

    assign in0_addr  = in0_data[ADDR_WIDTH-1:0];
    assign issue_tag = (HW_TYPE == 1) ? in0_tag : cfg_data;
    assign tag_ok    = (HW_TYPE == 0) || (in0_tag == in2_data);
    assign q_empty   = (count_q == '0);
    assign q_full    = (count_q == CNT_W'(QUEUE_DEPTH));

    // Full is judged on the registered count, so a pop never frees a slot in the same cycle.
    assign sync       = !rst && in0_valid && in2_valid && tag_ok && !q_full;
    assign out1_valid = sync;
    assign push       = sync && out1_ready;
    assign in0_ready  = push;
    assign in2_ready  = push;

    assign in1_ready  = !rst && !q_empty && (!out0_valid_q || out0_ready);
    assign pop        = in1_valid && in1_ready;

    if (TAG_WIDTH > 0) begin : g_tag
        logic [TW-1:0]    tag_mem_q [QUEUE_DEPTH];
        logic [TW-1:0]    tag_mem_d [QUEUE_DEPTH];
        logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

        always_comb begin
            tag_mem_d = tag_mem_q;
            wr_ptr_d  = wr_ptr_q;
            rd_ptr_d  = rd_ptr_q;
            if (push) begin
                tag_mem_d[wr_ptr_q] = issue_tag;
                wr_ptr_d            = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
            end
        end

        // Tag storage carries no control meaning, so it is left out of reset.
        always_ff @(posedge clk) begin
            tag_mem_q <= tag_mem_d;
        end

        assign in0_tag   = in0_data[ADDR_WIDTH +: TAG_WIDTH];
        assign head_tag  = tag_mem_q[rd_ptr_q];
        assign out1_data = {issue_tag, in0_addr};
        assign ret_word  = {head_tag, in1_data};
    end else begin : g_notag
        assign in0_tag   = '0;
        assign head_tag  = '0;
        assign out1_data = in0_addr;
        assign ret_word  = in1_data;
    end

    always_comb begin
        count_d      = count_q;
        out0_valid_d = out0_valid_q;
        out0_data_d  = out0_data_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        if (pop) begin
            out0_valid_d = 1'b1;
            out0_data_d  = ret_word;
        end else if (out0_ready) begin
            out0_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            out0_valid_q <= 1'b0;
            out0_data_q  <= '0;
        end else begin
            count_q      <= count_d;
            out0_valid_q <= out0_valid_d;
            out0_data_q  <= out0_data_d;
        end
    end

    assign pending    = count_q;
    assign out0_valid = out0_valid_q;
    assign out0_data  = out0_data_q;

`ifdef FABRIC_PE_LOADQ_ERR_EN
    logic       err_valid_q, err_valid_d;
    logic [3:0] err_code_q, err_code_d;

    // First orphan response wins; the flag is sticky until reset.
    always_comb begin
        err_valid_d = err_valid_q;
        err_code_d  = err_code_q;
        if (in1_valid && q_empty && !err_valid_q) begin
            err_valid_d = 1'b1;
            err_code_d  = 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid_q <= 1'b0;
            err_code_q  <= 4'd0;
        end else begin
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
`else
    assign err_valid = 1'b0;
    assign err_code  = 4'd0;
`endif

    logic unused_ok;
    assign unused_ok = ^{in0_data, in2_data, cfg_data, issue_tag, head_tag};

endmodule

// File: tb/tb_fabric_pe_load_q.sv
// Bench for fabric_pe_load_q: a tagged transparent instance (A) and an untagged overwrite instance (B).
module tb_fabric_pe_load_q;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance A: TAG_WIDTH 2, HW_TYPE 1
    logic       a_in0_valid, a_in0_ready, a_in1_valid, a_in1_ready, a_in2_valid, a_in2_ready;
    logic [9:0] a_in0_data;
    logic [7:0] a_in1_data;
    logic [1:0] a_in2_data, a_cfg_data;
    logic       a_out0_valid, a_out0_ready, a_out1_valid, a_out1_ready;
    logic [9:0] a_out0_data, a_out1_data;
    logic [2:0] a_pending;
    logic       a_err_valid;
    logic [3:0] a_err_code;

    // Instance B: untagged, HW_TYPE 0
    logic       b_in0_valid, b_in0_ready, b_in1_valid, b_in1_ready, b_in2_valid, b_in2_ready;
    logic [7:0] b_in0_data, b_in1_data;
    logic [0:0] b_in2_data, b_cfg_data;
    logic       b_out0_valid, b_out0_ready, b_out1_valid, b_out1_ready;
    logic [7:0] b_out0_data, b_out1_data;
    logic [2:0] b_pending;
    logic       b_err_valid;
    logic [3:0] b_err_code;

    fabric_pe_load_q #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .TAG_WIDTH(2), .HW_TYPE(1), .QUEUE_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst),
        .in0_valid(a_in0_valid), .in0_ready(a_in0_ready), .in0_data(a_in0_data),
        .in1_valid(a_in1_valid), .in1_ready(a_in1_ready), .in1_data(a_in1_data),
        .in2_valid(a_in2_valid), .in2_ready(a_in2_ready), .in2_data(a_in2_data),
        .out0_valid(a_out0_valid), .out0_ready(a_out0_ready), .out0_data(a_out0_data),
        .out1_valid(a_out1_valid), .out1_ready(a_out1_ready), .out1_data(a_out1_data),
        .cfg_data(a_cfg_data), .pending(a_pending), .err_valid(a_err_valid), .err_code(a_err_code)
    );

    fabric_pe_load_q #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .TAG_WIDTH(0), .HW_TYPE(0), .QUEUE_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst),
        .in0_valid(b_in0_valid), .in0_ready(b_in0_ready), .in0_data(b_in0_data),
        .in1_valid(b_in1_valid), .in1_ready(b_in1_ready), .in1_data(b_in1_data),
        .in2_valid(b_in2_valid), .in2_ready(b_in2_ready), .in2_data(b_in2_data),
        .out0_valid(b_out0_valid), .out0_ready(b_out0_ready), .out0_data(b_out0_data),
        .out1_valid(b_out1_valid), .out1_ready(b_out1_ready), .out1_data(b_out1_data),
        .cfg_data(b_cfg_data), .pending(b_pending), .err_valid(b_err_valid), .err_code(b_err_code)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for instance A: tags recorded at issue, tagged data expected at out0.
    logic [1:0] tag_q[$];
    logic [9:0] exp_q[$];

    always @(negedge clk) begin
        if (rst) begin
            tag_q.delete();
            exp_q.delete();
        end else begin
            chk("a_pending_model", 32'(a_pending), 32'(tag_q.size()));
            if (a_out0_valid && a_out0_ready) begin
                if (exp_q.size() == 0) chk("a_out0_unexpected", 32'(a_out0_data), 32'h0dead);
                else chk("a_out0_sb", 32'(a_out0_data), 32'(exp_q.pop_front()));
            end
            if (a_in1_valid && a_in1_ready) begin
                if (tag_q.size() == 0) chk("a_orphan_accepted", 32'(a_in1_ready), 32'd0);
                else exp_q.push_back({tag_q.pop_front(), a_in1_data});
            end
            if (a_out1_valid && a_out1_ready) begin
                chk("a_out1_issue", 32'(a_out1_data), 32'({a_in0_data[9:8], a_in0_data[7:0]}));
                tag_q.push_back(a_in0_data[9:8]);
            end
        end
    end

    typedef struct {
        logic [7:0] addr;
        logic [1:0] t0;
        logic [1:0] t2;
        logic       ordy;
        logic       exp_v;
        logic [9:0] exp_d;
        logic       exp_rdy;
    } vec_t;

    vec_t vecs[6];
    logic [1:0] ilv_tag[3];
    logic [9:0] ilv_exp[3];

    initial begin
        vecs[0] = '{8'h10, 2'd2, 2'd1, 1'b0, 1'b0, 10'h000, 1'b0};
        vecs[1] = '{8'h10, 2'd2, 2'd2, 1'b0, 1'b1, 10'h210, 1'b0};
        vecs[2] = '{8'hFF, 2'd3, 2'd3, 1'b0, 1'b1, 10'h3FF, 1'b0};
        vecs[3] = '{8'h00, 2'd0, 2'd3, 1'b0, 1'b0, 10'h000, 1'b0};
        vecs[4] = '{8'h5A, 2'd1, 2'd1, 1'b0, 1'b1, 10'h15A, 1'b0};
        vecs[5] = '{8'h22, 2'd2, 2'd1, 1'b1, 1'b0, 10'h000, 1'b0};
        ilv_tag[0] = 2'd3; ilv_tag[1] = 2'd0; ilv_tag[2] = 2'd1;
        ilv_exp[0] = 10'h3A1; ilv_exp[1] = 10'h0A2; ilv_exp[2] = 10'h1A3;

        rst = 1'b1;
        a_in0_valid = 0; a_in0_data = '0; a_in1_valid = 0; a_in1_data = '0;
        a_in2_valid = 0; a_in2_data = '0; a_cfg_data = '0; a_out0_ready = 1; a_out1_ready = 0;
        b_in0_valid = 0; b_in0_data = '0; b_in1_valid = 0; b_in1_data = '0;
        b_in2_valid = 0; b_in2_data = '0; b_cfg_data = '0; b_out0_ready = 1; b_out1_ready = 0;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst_out0_valid", 32'(a_out0_valid), 0);
        chk("rst_out0_data", 32'(a_out0_data), 0);
        chk("rst_out1_valid", 32'(a_out1_valid), 0);
        chk("rst_readies", 32'({a_in0_ready, a_in1_ready, a_in2_ready}), 0);
        chk("rst_pending", 32'(a_pending), 0);
        chk("rst_err", 32'({a_err_valid, a_err_code}), 0);
        chk("rst_b_pending", 32'(b_pending), 0);

        // Combinational issue path, nothing fires
        for (int i = 0; i < 6; i++) begin
            a_in0_valid = 1; a_in2_valid = 1;
            a_in0_data = {vecs[i].t0, vecs[i].addr};
            a_in2_data = vecs[i].t2;
            a_out1_ready = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d_out1_valid", i), 32'(a_out1_valid), 32'(vecs[i].exp_v));
            if (vecs[i].exp_v) chk($sformatf("vec%0d_out1_data", i), 32'(a_out1_data), 32'(vecs[i].exp_d));
            chk($sformatf("vec%0d_in0_ready", i), 32'(a_in0_ready), 32'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d_in2_ready", i), 32'(a_in2_ready), 32'(vecs[i].exp_rdy));
            cyc();
        end
        a_in0_valid = 0; a_in2_valid = 0;
        #1; chk("vec_pending", 32'(a_pending), 0);
        cyc();

        // Tag mismatch holds both inputs, then matching tag fires
        a_in0_valid = 1; a_in2_valid = 1; a_in0_data = {2'd2, 8'h40}; a_in2_data = 2'd1; a_out1_ready = 1;
        repeat (5) begin
            #1;
            chk("mm_out1_valid", 32'(a_out1_valid), 0);
            chk("mm_readies", 32'({a_in0_ready, a_in2_ready}), 0);
            cyc();
        end
        a_in2_data = 2'd2;
        #1;
        chk("mm_fire_valid", 32'(a_out1_valid), 1);
        chk("mm_fire_ready", 32'({a_in0_ready, a_in2_ready}), 32'b11);
        chk("mm_fire_data", 32'(a_out1_data), 32'h240);
        cyc();
        a_in0_valid = 0; a_in2_valid = 0;
        #1; chk("mm_pending", 32'(a_pending), 1);
        a_in1_valid = 1; a_in1_data = 8'h55;
        #1; chk("mm_in1_ready", 32'(a_in1_ready), 1);
        cyc();
        a_in1_valid = 0;
        #1;
        chk("mm_out0_valid", 32'(a_out0_valid), 1);
        chk("mm_out0_data", 32'(a_out0_data), 32'h255);
        cyc();
        #1; chk("mm_out0_drain", 32'(a_out0_valid), 0);

        // Interleaved tags 3, 0, 1 then in-order return while mismatched in0 is presented
        for (int i = 0; i < 3; i++) begin
            a_in0_valid = 1; a_in2_valid = 1;
            a_in0_data = {ilv_tag[i], 8'h30 + 8'(i)}; a_in2_data = ilv_tag[i];
            #1; chk("ilv_fire", 32'(a_in0_ready), 1);
            cyc();
        end
        a_in0_data = {2'd2, 8'h77}; a_in2_data = 2'd1;
        #1; chk("ilv_pending", 32'(a_pending), 3);
        for (int i = 0; i < 3; i++) begin
            a_in1_valid = 1; a_in1_data = 8'hA1 + 8'(i);
            #1;
            chk("ilv_in1_ready", 32'(a_in1_ready), 1);
            chk("ilv_no_issue", 32'(a_out1_valid), 0);
            if (i > 0) chk("ilv_out0_data", 32'(a_out0_data), 32'(ilv_exp[i-1]));
            cyc();
        end
        a_in1_valid = 0;
        #1; chk("ilv_out0_last", 32'(a_out0_data), 32'(ilv_exp[2]));
        a_in0_valid = 0; a_in2_valid = 0;
        cyc();
        #1; chk("ilv_done", 32'({a_out0_valid, a_pending}), 0);

        // Fill to capacity; a pop does not enable a push in the same cycle
        a_in0_valid = 1; a_in2_valid = 1; a_in2_data = 2'd1;
        for (int i = 0; i < 4; i++) begin
            a_in0_data = {2'd1, 8'h80 + 8'(i)};
            #1; chk("full_fill", 32'(a_in0_ready), 1);
            cyc();
        end
        a_in0_data = {2'd1, 8'h84};
        repeat (2) begin
            #1;
            chk("full_stall_valid", 32'(a_out1_valid), 0);
            chk("full_stall_ready", 32'(a_in0_ready), 0);
            chk("full_pending", 32'(a_pending), 4);
            cyc();
        end
        a_in1_valid = 1; a_in1_data = 8'hC0;
        #1;
        chk("full_pop_ready", 32'(a_in1_ready), 1);
        chk("full_no_bypass", 32'(a_out1_valid), 0);
        cyc();
        a_in1_valid = 0;
        #1;
        chk("full_resume_pending", 32'(a_pending), 3);
        chk("full_resume_valid", 32'(a_out1_valid), 1);
        cyc();
        a_in0_valid = 0; a_in2_valid = 0;
        #1; chk("full_refill", 32'(a_pending), 4);

        // Output backpressure with response waiting
        a_out0_ready = 0;
        a_in1_valid = 1; a_in1_data = 8'hC1;
        #1; chk("bp_first_ready", 32'(a_in1_ready), 1);
        cyc();
        a_in1_data = 8'hC2;
        repeat (3) begin
            #1;
            chk("bp_in1_ready", 32'(a_in1_ready), 0);
            chk("bp_out0_valid", 32'(a_out0_valid), 1);
            chk("bp_out0_data", 32'(a_out0_data), 32'h1C1);
            cyc();
        end
        a_out0_ready = 1;
        for (int j = 2; j <= 4; j++) begin
            a_in1_data = 8'hC0 + 8'(j);
            #1;
            chk("bp_stream_ready", 32'(a_in1_ready), 1);
            chk("bp_stream_data", 32'(a_out0_data), 32'({2'd1, 8'hC0 + 8'(j - 1)}));
            cyc();
        end
        a_in1_valid = 0;
        #1; chk("bp_last", 32'(a_out0_data), 32'h1C4);
        cyc();
        #1; chk("bp_done", 32'({a_out0_valid, a_pending}), 0);

        // Reset mid-operation, then orphan response
        a_in0_valid = 1; a_in2_valid = 1; a_in2_data = 2'd3;
        for (int i = 0; i < 2; i++) begin
            a_in0_data = {2'd3, 8'h90 + 8'(i)};
            cyc();
        end
        a_in0_valid = 0; a_in2_valid = 0;
        #1; chk("mid_pending", 32'(a_pending), 2);
        rst = 1;
        cyc();
        rst = 0;
        #1; chk("mid_flushed", 32'({a_out0_valid, a_pending}), 0);
        a_in1_valid = 1; a_in1_data = 8'hEE;
        #1; chk("orphan_ready", 32'(a_in1_ready), 0);
        cyc();
        a_in1_valid = 0;
        #1;
        chk("orphan_ready_hold", 32'(a_in1_ready), 0);
`ifdef FABRIC_PE_LOADQ_ERR_EN
        chk("err_set", 32'({a_err_valid, a_err_code}), 32'h11);
`else
        chk("err_tied", 32'({a_err_valid, a_err_code}), 0);
`endif
        cyc();
        #1;
`ifdef FABRIC_PE_LOADQ_ERR_EN
        chk("err_sticky", 32'({a_err_valid, a_err_code}), 32'h11);
`else
        chk("err_tied_hold", 32'({a_err_valid, a_err_code}), 0);
`endif
        rst = 1;
        cyc();
        rst = 0;
        #1; chk("err_cleared", 32'({a_err_valid, a_err_code}), 0);

        // Untagged instance: 3 back-to-back issues then 3 returns
        b_in0_valid = 1; b_in2_valid = 1; b_out1_ready = 1;
        for (int i = 0; i < 3; i++) begin
            b_in0_data = 8'h10 + 8'(4 * i);
            #1;
            chk("b_out1_valid", 32'(b_out1_valid), 1);
            chk("b_out1_data", 32'(b_out1_data), 32'(8'h10 + 8'(4 * i)));
            chk("b_in0_ready", 32'(b_in0_ready), 1);
            chk("b_pending_up", 32'(b_pending), 32'(i));
            cyc();
        end
        b_in0_valid = 0; b_in2_valid = 0;
        #1; chk("b_pending3", 32'(b_pending), 3);
        for (int i = 0; i < 3; i++) begin
            b_in1_valid = 1; b_in1_data = 8'h0A + 8'(i);
            #1;
            chk("b_in1_ready", 32'(b_in1_ready), 1);
            chk("b_pending_down", 32'(b_pending), 32'(3 - i));
            if (i > 0) chk("b_out0_data", 32'(b_out0_data), 32'(8'h0A + 8'(i - 1)));
            cyc();
        end
        b_in1_valid = 0;
        #1;
        chk("b_out0_last", 32'({b_out0_valid, b_out0_data}), 32'h10C);
        cyc();
        #1; chk("b_done", 32'({b_out0_valid, b_pending}), 0);

        chk("sb_empty", 32'(exp_q.size() + tag_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
